multicycle_control: RTL and testbench

Multi-cycle control unit for the RV32 datapath. It decodes the packed opcode/funct field, sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback), stalls on a memory ready handshake, and flags illegal encodings by parking in a trap state. It sits between the instruction register and the shared ALU/memory/register-file datapath, and drives every enable and mux select per cycle.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/alu_decoder.sv | 34 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control unit.
// The JAL state exists only when CTRL_JAL_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OpRtype = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [3:0] AluAnd     = 4'b0000;
  localparam logic [3:0] AluOr      = 4'b0001;
  localparam logic [3:0] AluAdd     = 4'b0010;
  localparam logic [3:0] AluSub     = 4'b0110;
  localparam logic [3:0] AluInvalid = 4'b1111;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluReg = 2'b00;
  localparam logic [1:0] ResMem    = 2'b01;
  localparam logic [1:0] ResAluOut = 2'b10;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
`ifdef CTRL_JAL_EN
    StJal,
`endif
    StTrap
  } ctrl_state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps {opcode class, funct3, instr[30]} to an ALU code plus a funct-illegal flag.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       is_rtype_i,
  input  logic [2:0] funct3_i,
  input  logic       b10_i,
  output logic [3:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = AluInvalid;
    illegal_o = 1'b1;
    if (is_rtype_i) begin
      case ({b10_i, funct3_i})
        4'b0000: begin alu_op_o = AluAdd; illegal_o = 1'b0; end
        4'b1000: begin alu_op_o = AluSub; illegal_o = 1'b0; end
        4'b0110: begin alu_op_o = AluOr;  illegal_o = 1'b0; end
        4'b0111: begin alu_op_o = AluAnd; illegal_o = 1'b0; end
        default: ;
      endcase
    end else begin
      // I-type ALU ops ignore instr[30]
      case (funct3_i)
        3'b000:  begin alu_op_o = AluAdd; illegal_o = 1'b0; end
        3'b110:  begin alu_op_o = AluOr;  illegal_o = 1'b0; end
        3'b111:  begin alu_op_o = AluAnd; illegal_o = 1'b0; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-FSM control unit for the multi-cycle RV32 datapath.
// Define CTRL_JAL_EN to decode JAL; otherwise JAL opcodes trap.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [10:0]        instr,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               branch,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       opcode;
  logic [3:0]       dec_op, op4;
  logic             dec_illegal, retire;

  assign opcode = instr[6:0];

  alu_decoder u_alu_decoder (
    .is_rtype_i (state_q == StExecR),
    .funct3_i   (instr[9:7]),
    .b10_i      (instr[10]),
    .alu_op_o   (dec_op),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecR;
          OpIAlu:     state_d = StExecI;
          OpBeq:      state_d = StBeq;
`ifdef CTRL_JAL_EN
          OpJal:      state_d = StJal;
`endif
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) begin state_d = StFetch; retire = 1'b1; end
      StExecR, StExecI: state_d = dec_illegal ? StTrap : StAluWb;
      StMemWb, StAluWb, StBeq: begin state_d = StFetch; retire = 1'b1; end
`ifdef CTRL_JAL_EN
      StJal:      begin state_d = StFetch; retire = 1'b1; end
`endif
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    result_src = ResAluReg;
    op4        = AluAnd;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SrcBFour;
        op4        = AluAdd;
        result_src = ResAluOut;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        op4       = AluAdd;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        op4       = AluAdd;
      end
      StMemRead:  begin adr_src = 1'b1; mem_read = 1'b1; end
      StMemWb:    begin result_src = ResMem; reg_write = 1'b1; end
      StMemWrite: begin adr_src = 1'b1; mem_write = 1'b1; end
      StExecR, StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = (state_q == StExecI) ? SrcBImm : SrcBRs2;
        op4       = dec_op;
      end
      StAluWb:    reg_write = 1'b1;
      StBeq: begin
        alu_src_a = SrcARs1;
        op4       = AluSub;
        branch    = 1'b1;
      end
`ifdef CTRL_JAL_EN
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        op4       = AluAdd;
        pc_write  = 1'b1;
        reg_write = 1'b1;
      end
`endif
      StTrap:     begin op4 = AluInvalid; illegal = 1'b1; end
      default: ;
    endcase
    // Reset masks every output combinationally, trap included
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      op4        = 4'b0000;
      illegal    = 1'b0;
    end
  end

  assign alu_op      = ALUOP_W'(op4);
  assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance (CNT_W=2, ALUOP_W=6)
// shares the stimulus to cover counter wrap and alu_op zero-extension.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] instr;
  logic        mem_ready;

  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, branch, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_op;
  logic [15:0] instr_count;

  logic       d2_pc_write, d2_ir_write, d2_adr_src, d2_mem_read, d2_mem_write;
  logic       d2_reg_write, d2_branch, d2_illegal;
  logic [1:0] d2_alu_src_a, d2_alu_src_b, d2_result_src;
  logic [5:0] d2_alu_op;
  logic [1:0] d2_instr_count;

  logic [17:0] ctl;
  logic [19:0] d2_ctl;
  assign ctl = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, branch,
                alu_src_a, alu_src_b, result_src, alu_op, illegal};
  assign d2_ctl = {d2_pc_write, d2_ir_write, d2_adr_src, d2_mem_read, d2_mem_write,
                   d2_reg_write, d2_branch, d2_alu_src_a, d2_alu_src_b, d2_result_src,
                   d2_alu_op, d2_illegal};

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_control #(.ALUOP_W(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_write(d2_pc_write), .ir_write(d2_ir_write), .adr_src(d2_adr_src),
    .mem_read(d2_mem_read), .mem_write(d2_mem_write), .reg_write(d2_reg_write),
    .branch(d2_branch), .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b),
    .result_src(d2_result_src), .alu_op(d2_alu_op), .illegal(d2_illegal),
    .instr_count(d2_instr_count)
  );

  always #5 clk = ~clk;

  // {pc_w, ir_w, adr, mrd, mwr, rw, br, srcA, srcB, res, op, ill}
  localparam logic [17:0] EFetch  = 18'b1_1_0_1_0_0_0_00_10_10_0010_0;
  localparam logic [17:0] EDecode = 18'b0_0_0_0_0_0_0_01_01_00_0010_0;
  localparam logic [17:0] EMemAdr = 18'b0_0_0_0_0_0_0_10_01_00_0010_0;
  localparam logic [17:0] EMemRd  = 18'b0_0_1_1_0_0_0_00_00_00_0000_0;
  localparam logic [17:0] EMemWb  = 18'b0_0_0_0_0_1_0_00_00_01_0000_0;
  localparam logic [17:0] EMemWr  = 18'b0_0_1_0_1_0_0_00_00_00_0000_0;
  localparam logic [17:0] EAluWb  = 18'b0_0_0_0_0_1_0_00_00_00_0000_0;
  localparam logic [17:0] EBeq    = 18'b0_0_0_0_0_0_1_10_00_00_0110_0;
  localparam logic [17:0] EJal    = 18'b1_0_0_0_0_1_0_01_10_00_0010_0;
  localparam logic [17:0] ETrap   = 18'b0_0_0_0_0_0_0_00_00_00_1111_1;

  localparam logic [10:0] IBeq = {1'b0, 3'b000, 7'b1100011};
  localparam logic [10:0] ISw  = {1'b0, 3'b010, 7'b0100011};

  int n_checks = 0;
  int n_bad    = 0;
  int exp_cnt  = 0;

  function automatic logic [17:0] exec_exp(input bit is_i, input logic [3:0] op);
    return {7'b0, 2'b10, (is_i ? 2'b01 : 2'b00), 2'b00, op, 1'b0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr = '0; mem_ready = 1'b0;
    tick(); tick(); #1;
    n_checks++;
    if (ctl !== 18'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", ctl);
    end
    n_checks++;
    if (instr_count !== 16'd0 || d2_instr_count !== 2'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d/%0d want 0", instr_count, d2_instr_count);
    end
    rst = 1'b0; exp_cnt = 0; #1;
    n_checks++;
    if (ctl !== EFetch) begin
      n_bad++; $display("FAIL reset_first_fetch: got %b want %b", ctl, EFetch);
    end
  endtask

  task automatic test_alu(input logic [10:0] ins, input logic [3:0] op, input bit is_i,
                          input string name);
    logic [17:0] exp [4];
    exp = '{EFetch, EDecode, exec_exp(is_i, op), EAluWb};
    for (int i = 0; i < 4; i++) begin
      instr = ins; mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL %s cyc%0d: got %b want %b", name, i, ctl, exp[i]);
      end
      n_checks++;
      if (d2_ctl !== {exp[i][17:5], 2'b00, exp[i][4:0]}) begin
        n_bad++; $display("FAIL %s_wide cyc%0d: got %b want %b", name, i, d2_ctl,
                          {exp[i][17:5], 2'b00, exp[i][4:0]});
      end
      tick();
    end
    exp_cnt++; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL %s_retire: ctl %b cnt %0d want %b cnt %0d", name, ctl,
                        instr_count, EFetch, exp_cnt);
    end
  endtask

  task automatic test_lw_stall;
    logic [17:0] exp [7];
    logic        rdy [7];
    exp = '{EFetch, EDecode, EMemAdr, EMemRd, EMemRd, EMemRd, EMemWb};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      instr = {1'b0, 3'b010, 7'b0000011}; mem_ready = rdy[i]; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL lw_stall cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      tick();
    end
    exp_cnt++; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL lw_retire: ctl %b cnt %0d want cnt %0d", ctl, instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw_stall;
    logic [17:0] exp [6];
    logic        rdy [6];
    exp = '{EFetch, EFetch, EDecode, EMemAdr, EMemWr, EMemWr};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      instr = ISw; mem_ready = rdy[i]; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL sw_stall cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      n_checks++;
      if (instr_count !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL sw_early_count cyc%0d: got %0d want %0d", i, instr_count, exp_cnt);
      end
      tick();
    end
    exp_cnt++; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL sw_retire: ctl %b cnt %0d want cnt %0d", ctl, instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq;
    logic [17:0] exp [3];
    exp = '{EFetch, EDecode, EBeq};
    for (int i = 0; i < 3; i++) begin
      instr = IBeq; mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL beq cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      tick();
    end
    exp_cnt++; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL beq_retire: ctl %b cnt %0d want cnt %0d", ctl, instr_count, exp_cnt);
    end
  endtask

  // Runs FETCH, DECODE, <mid state> into TRAP, holds it, then resets out
  task automatic test_trap(input logic [10:0] ins, input bit via_exec, input string name);
    int n_pre;
    n_pre = via_exec ? 3 : 2;
    instr = ins; mem_ready = 1'b1; #1;
    n_checks++;
    if (ctl !== EFetch) begin
      n_bad++; $display("FAIL %s_fetch: got %b want %b", name, ctl, EFetch);
    end
    for (int i = 0; i < n_pre; i++) tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0]; #1;
      n_checks++;
      if (ctl !== ETrap || instr_count !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL %s_hold cyc%0d: ctl %b cnt %0d want %b cnt %0d", name, i,
                          ctl, instr_count, ETrap, exp_cnt);
      end
      tick();
    end
    rst = 1'b1; #1;
    n_checks++;
    if (ctl !== 18'b0 || instr_count !== 16'd0) begin
      n_bad++; $display("FAIL %s_rst: ctl %b cnt %0d want 0", name, ctl, instr_count);
    end
    tick(); rst = 1'b0; exp_cnt = 0; #1;
    n_checks++;
    if (ctl !== EFetch) begin
      n_bad++; $display("FAIL %s_exit: got %b want %b", name, ctl, EFetch);
    end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 4; k++) begin
      instr = IBeq; mem_ready = 1'b1;
      tick(); tick(); tick();
      exp_cnt++; #1;
      n_checks++;
      if (d2_instr_count !== 2'(exp_cnt % 4) || instr_count !== 16'(exp_cnt)) begin
        n_bad++; $display("FAIL wrap k%0d: got %0d/%0d want %0d/%0d", k, d2_instr_count,
                          instr_count, exp_cnt % 4, exp_cnt);
      end
    end
  endtask

  task automatic test_jal;
`ifdef CTRL_JAL_EN
    logic [17:0] exp [3];
    exp = '{EFetch, EDecode, EJal};
    for (int i = 0; i < 3; i++) begin
      instr = {1'b0, 3'b000, 7'b1101111}; mem_ready = 1'b1; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL jal cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      tick();
    end
    exp_cnt++; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL jal_retire: ctl %b cnt %0d want cnt %0d", ctl, instr_count, exp_cnt);
    end
`else
    test_trap({1'b0, 3'b000, 7'b1101111}, 1'b0, "jal_off");
`endif
  endtask

  task automatic test_reset_mid_write;
    logic [17:0] exp [5];
    logic        rdy [5];
    exp = '{EFetch, EDecode, EMemAdr, EMemWr, EMemWr};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      instr = ISw; mem_ready = rdy[i]; #1;
      n_checks++;
      if (ctl !== exp[i]) begin
        n_bad++; $display("FAIL rstwr cyc%0d: got %b want %b", i, ctl, exp[i]);
      end
      if (i < 4) tick();
    end
    rst = 1'b1; #1;
    n_checks++;
    if (ctl !== 18'b0 || instr_count !== 16'd0 || d2_instr_count !== 2'd0) begin
      n_bad++; $display("FAIL rstwr_hold: ctl %b cnt %0d want 0", ctl, instr_count);
    end
    tick(); rst = 1'b0; instr = IBeq; mem_ready = 1'b1; exp_cnt = 0; #1;
    n_checks++;
    if (ctl !== EFetch || instr_count !== 16'd0) begin
      n_bad++; $display("FAIL rstwr_fetch: ctl %b cnt %0d want %b 0", ctl, instr_count, EFetch);
    end
    tick(); #1;
    n_checks++;
    if (ctl !== EDecode || mem_write !== 1'b0) begin
      n_bad++; $display("FAIL rstwr_decode: got %b want %b", ctl, EDecode);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, want finish before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu({1'b0, 3'b000, 7'b0110011}, 4'b0010, 1'b0, "r_add");
    test_alu({1'b1, 3'b000, 7'b0110011}, 4'b0110, 1'b0, "r_sub");
    test_alu({1'b0, 3'b111, 7'b0110011}, 4'b0000, 1'b0, "r_and");
    test_alu({1'b1, 3'b110, 7'b0010011}, 4'b0001, 1'b1, "i_or");
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_trap({1'b1, 3'b111, 7'b0110011}, 1'b1, "r_illegal");
    test_wrap();
    test_trap({1'b0, 3'b001, 7'b0010011}, 1'b1, "i_illegal");
    test_trap({1'b0, 3'b000, 7'b1111111}, 1'b0, "bad_opcode");
    test_jal();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
